hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage RV32I core.
//  - Drives enable/flush of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
//  - Detects load-use and taken-branch hazards and produces EX-stage forwarding selects.
//  - Freezes the pipeline through a multi-cycle data-memory handshake, with timeout.
//  - Keeps a saturating stall-cycle counter.
// PARAMETERS
//  MEM_TIMEOUT  16  max wait cycles for i_mem_ready before abort (>=2)
//  CNT_W        16  width of stall-cycle counter
// PORTS
//  i_clk            in   1   clock, rising edge
//  i_rst_n          in   1   asynchronous active-low reset
//  i_rs1_ID         in   5   rs1 of instr in ID
//  i_rs2_ID         in   5   rs2 of instr in ID
//  i_rs1_EX         in   5   rs1 of instr in EX
//  i_rs2_EX         in   5   rs2 of instr in EX
//  i_rd_EX          in   5   rd of instr in EX
//  i_rd_MEM         in   5   rd of instr in MEM
//  i_rd_WB          in   5   rd of instr in WB
//  i_result_src_EX  in   2   result select of EX instr; RESULT_SRC_LOAD marks a load
//  i_reg_write_MEM  in   1   MEM instr writes rd
//  i_reg_write_WB   in   1   WB instr writes rd
//  i_pc_src_EX      in   1   branch/jump taken in EX
//  i_mem_req_MEM    in   1   load/store in MEM requesting dmem
//  i_mem_ready      in   1   dmem completes access this cycle
//  o_stall_IF       out  1   hold PC
//  o_stall_ID       out  1   hold IF/ID register
//  o_stall_EX       out  1   hold ID/EX register
//  o_stall_MEM      out  1   hold EX/MEM register
//  o_flush_ID       out  1   clear IF/ID to NOP
//  o_flush_EX       out  1   clear ID/EX to bubble
//  o_flush_WB       out  1   insert bubble into MEM/WB (reg_write=0)
//  o_fwd_a_EX       out  2   fwd_sel_e for ALU operand A
//  o_fwd_b_EX       out  2   fwd_sel_e for ALU operand B
//  o_mem_err        out  1   one-cycle pulse on dmem timeout
//  o_stall_cnt      out  CNT_W  total stalled cycles, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, state RUN, wait counter 0, o_stall_cnt 0.
//  - Forwarding (comb) for operand A, same rule on rs2 for B:
//    - FWD_MEM if i_reg_write_MEM && rd_MEM!=0 && rd_MEM==rs1_EX.
//    - else FWD_WB if i_reg_write_WB && rd_WB!=0 && rd_WB==rs1_EX.
//    - else FWD_NONE. MEM beats WB. x0 is never forwarded.
//  - lw_stall = (i_result_src_EX==RESULT_SRC_LOAD) && rd_EX!=0 && (rd_EX==rs1_ID || rd_EX==rs2_ID).
//  - FSM states RUN and MEM_WAIT.
//  - RUN:
//    - mem_hold = i_mem_req_MEM && !i_mem_ready. If set: next MEM_WAIT, wait cnt<=1.
//    - If !mem_hold: stall_IF=stall_ID=lw_stall; flush_EX=lw_stall|pc_src_EX; flush_ID=pc_src_EX.
//  - MEM_WAIT:
//    - !i_mem_ready: stay; wait cnt++.
//    - i_mem_ready: next RUN; the hold releases this same cycle.
//    - wait cnt==MEM_TIMEOUT-1 with !ready: pulse o_mem_err, next RUN, release hold, cnt<=0.
//  - Hold (RUN with mem_hold, or MEM_WAIT with !ready and no timeout):
//    - stall_IF/ID/EX/MEM=1, flush_WB=1, flush_ID=flush_EX=0.
//    - Hold overrides lw_stall and pc_src_EX; they are re-evaluated after release.
//  - lw_stall and pc_src_EX are mutually exclusive (one EX instr). An assertion checks this.
//  - o_stall_cnt += 1 on every cycle with stall_IF=1; saturates at all-ones.
//  - Async reset mid-wait: immediate return to RUN, all stalls/flushes deassert.
// STRUCTURE
//  - pipeline_pkg holds:
//    - fwd_sel_e {FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}
//    - RESULT_SRC_LOAD=2'b01
//    - hz_state_e {RUN, MEM_WAIT}
//  - Sub-module fwd_unit: combinational forwarding selects, instanced twice (A, B).
// TESTING
//  - Load x5 in EX, ID reads rs1=x5 -> stall_IF=stall_ID=flush_EX=1 for 1 cycle; next cycle fwd_a_EX=FWD_MEM.
//  - rd_MEM=rd_WB=x7, both reg_write, rs2_EX=x7 -> fwd_b_EX=FWD_MEM. With rd=x0 -> FWD_NONE.
//  - pc_src_EX=1 -> flush_ID=flush_EX=1, no stalls.
//  - mem_req=1, ready low 3 cycles then high -> 3 hold cycles, flush_WB=1, o_stall_cnt=3.
//  - ready never rises, MEM_TIMEOUT=16 -> o_mem_err pulses in cycle 16, stalls drop the same cycle.
//  - Assert i_rst_n low during MEM_WAIT -> outputs 0 asynchronously. Saturation checked with CNT_W=2.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the RV32I pipeline control: forwarding selects,
// result-source encodings and the hazard sequencer state.
package pipeline_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding select for one ALU operand.
// The MEM-stage result is younger than the WB-stage result, so it wins.
// x0 is hard-wired zero and is never forwarded.
module fwd_unit
    import pipeline_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_mem,
    input  logic [4:0] rd_wb,
    input  logic       reg_write_mem,
    input  logic       reg_write_wb,
    output fwd_sel_e   sel
);

    // Priority select: MEM first, then WB, otherwise the register file value.
    always_comb begin
        sel = FWD_NONE;
        if (reg_write_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage RV32I core.
// Produces stall/flush controls for the pipeline registers, EX-stage
// forwarding selects, freezes the pipe during a slow data-memory access
// (with a timeout that aborts the access) and counts stalled cycles.
//
// Handshake with data memory: a request is presented while i_mem_req_MEM is
// high; the access completes in any cycle where i_mem_ready is high. Until
// then the whole pipe is held and a bubble is pushed into MEM/WB. The hold
// releases in the same cycle ready is seen.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [4:0]       i_rs1_ID,
    input  logic [4:0]       i_rs2_ID,
    input  logic [4:0]       i_rs1_EX,
    input  logic [4:0]       i_rs2_EX,
    input  logic [4:0]       i_rd_EX,
    input  logic [4:0]       i_rd_MEM,
    input  logic [4:0]       i_rd_WB,
    input  logic [1:0]       i_result_src_EX,
    input  logic             i_reg_write_MEM,
    input  logic             i_reg_write_WB,
    input  logic             i_pc_src_EX,
    input  logic             i_mem_req_MEM,
    input  logic             i_mem_ready,
    output logic             o_stall_IF,
    output logic             o_stall_ID,
    output logic             o_stall_EX,
    output logic             o_stall_MEM,
    output logic             o_flush_ID,
    output logic             o_flush_EX,
    output logic             o_flush_WB,
    output fwd_sel_e         o_fwd_a_EX,
    output fwd_sel_e         o_fwd_b_EX,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_cnt,
    output hz_state_e        o_dbg_state
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_e         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              lw_stall;
    logic              mem_hold;
    logic              timeout;
    logic              hold;
    logic              stall_fe;
    logic              flush_id_c;
    logic              flush_ex_c;

    fwd_unit u_fwd_a (
        .rs            (i_rs1_EX),
        .rd_mem        (i_rd_MEM),
        .rd_wb         (i_rd_WB),
        .reg_write_mem (i_reg_write_MEM),
        .reg_write_wb  (i_reg_write_WB),
        .sel           (o_fwd_a_EX)
    );

    fwd_unit u_fwd_b (
        .rs            (i_rs2_EX),
        .rd_mem        (i_rd_MEM),
        .rd_wb         (i_rd_WB),
        .reg_write_mem (i_reg_write_MEM),
        .reg_write_wb  (i_reg_write_WB),
        .sel           (o_fwd_b_EX)
    );

    // Hazard decode: load-use, memory hold, timeout and the resulting controls.
    always_comb begin
        lw_stall   = (i_result_src_EX == RESULT_SRC_LOAD) && (i_rd_EX != 5'd0) &&
                     ((i_rd_EX == i_rs1_ID) || (i_rd_EX == i_rs2_ID));
        mem_hold   = i_mem_req_MEM && !i_mem_ready;
        timeout    = (state == MEM_WAIT) && !i_mem_ready && (wait_cnt == WAIT_LAST);
        hold       = ((state == RUN) && mem_hold) ||
                     ((state == MEM_WAIT) && !i_mem_ready && !timeout);
        stall_fe   = 1'b0;
        flush_id_c = 1'b0;
        flush_ex_c = 1'b0;
        if (hold) begin
            stall_fe = 1'b1;
        end else if (!timeout) begin
            stall_fe   = lw_stall;
            flush_ex_c = lw_stall || i_pc_src_EX;
            flush_id_c = i_pc_src_EX;
        end
    end

    // Controls are forced low while reset is asserted, independent of inputs.
    assign o_stall_IF  = i_rst_n && stall_fe;
    assign o_stall_ID  = i_rst_n && stall_fe;
    assign o_stall_EX  = i_rst_n && hold;
    assign o_stall_MEM = i_rst_n && hold;
    assign o_flush_WB  = i_rst_n && hold;
    assign o_flush_ID  = i_rst_n && flush_id_c;
    assign o_flush_EX  = i_rst_n && flush_ex_c;
    assign o_mem_err   = i_rst_n && timeout;
    assign o_dbg_state = state;

    // Memory-wait FSM and its wait-cycle counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_hold) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (i_mem_ready || timeout) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the front end was held.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
        end else if (o_stall_IF && (o_stall_cnt != {CNT_W{1'b1}})) begin
            o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end

    // A single EX instruction cannot be both a load and a taken branch.
    a_lw_pc_excl : assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                    !(lw_stall && i_pc_src_EX));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle vector table plus sequences
// for the memory hold, timeout, async reset and counter saturation.
module tb_hazard_ctrl;
    import pipeline_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
    logic [1:0] rsrc;
    logic       rw_mem, rw_wb, pc_src, mem_req, mem_ready;

    logic        s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, m_err;
    fwd_sel_e    fa, fb;
    logic [15:0] cnt;
    hz_state_e   st;

    logic        z_if, z_id, z_ex, z_mem, zf_id, zf_ex, zf_wb, z_err;
    fwd_sel_e    za, zb;
    logic [1:0]  z_cnt;
    hz_state_e   z_st;

    hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs1_ID(rs1_id), .i_rs2_ID(rs2_id), .i_rs1_EX(rs1_ex), .i_rs2_EX(rs2_ex),
        .i_rd_EX(rd_ex), .i_rd_MEM(rd_mem), .i_rd_WB(rd_wb),
        .i_result_src_EX(rsrc), .i_reg_write_MEM(rw_mem), .i_reg_write_WB(rw_wb),
        .i_pc_src_EX(pc_src), .i_mem_req_MEM(mem_req), .i_mem_ready(mem_ready),
        .o_stall_IF(s_if), .o_stall_ID(s_id), .o_stall_EX(s_ex), .o_stall_MEM(s_mem),
        .o_flush_ID(f_id), .o_flush_EX(f_ex), .o_flush_WB(f_wb),
        .o_fwd_a_EX(fa), .o_fwd_b_EX(fb), .o_mem_err(m_err),
        .o_stall_cnt(cnt), .o_dbg_state(st)
    );

    hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rs1_ID(rs1_id), .i_rs2_ID(rs2_id), .i_rs1_EX(rs1_ex), .i_rs2_EX(rs2_ex),
        .i_rd_EX(rd_ex), .i_rd_MEM(rd_mem), .i_rd_WB(rd_wb),
        .i_result_src_EX(rsrc), .i_reg_write_MEM(rw_mem), .i_reg_write_WB(rw_wb),
        .i_pc_src_EX(pc_src), .i_mem_req_MEM(mem_req), .i_mem_ready(mem_ready),
        .o_stall_IF(z_if), .o_stall_ID(z_id), .o_stall_EX(z_ex), .o_stall_MEM(z_mem),
        .o_flush_ID(zf_id), .o_flush_EX(zf_ex), .o_flush_WB(zf_wb),
        .o_fwd_a_EX(za), .o_fwd_b_EX(zb), .o_mem_err(z_err),
        .o_stall_cnt(z_cnt), .o_dbg_state(z_st)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;
    logic [11:0] exp_q[$];

    // Output bundle: {stall IF,ID,EX,MEM, flush ID,EX,WB, fwd_a, fwd_b, mem_err}
    localparam logic [11:0] O_IDLE = 12'b0000_000_00_00_0;
    localparam logic [11:0] O_LW   = 12'b1100_010_00_00_0;
    localparam logic [11:0] O_HOLD = 12'b1111_001_00_00_0;
    localparam logic [11:0] O_ERR  = 12'b0000_000_00_00_1;

    function automatic logic [11:0] act_vec();
        return {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb, fa, fb, m_err};
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Compare outputs against the queued expectation and the stall-count model.
    task automatic check_cycle(input string name);
        logic [11:0] e;
        e = exp_q.pop_front();
        check_val({name, "_out"}, 32'(act_vec()), 32'(e));
        check_val({name, "_cnt"}, 32'(cnt), 32'(exp_cnt));
        if (e[11] && exp_cnt < 65535) exp_cnt++;
    endtask

    // ---------------- driver tasks ----------------
    typedef struct {
        logic [4:0]  rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
        logic [1:0]  rsrc;
        logic        rw_mem, rw_wb, pc_src;
        logic [11:0] exp;
    } vec_t;

    task automatic clear_inputs();
        rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0;
        rd_ex = '0; rd_mem = '0; rd_wb = '0; rsrc = '0;
        rw_mem = 1'b0; rw_wb = 1'b0; pc_src = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v);
        rs1_id = v.rs1_id; rs2_id = v.rs2_id; rs1_ex = v.rs1_ex; rs2_ex = v.rs2_ex;
        rd_ex = v.rd_ex; rd_mem = v.rd_mem; rd_wb = v.rd_wb; rsrc = v.rsrc;
        rw_mem = v.rw_mem; rw_wb = v.rw_wb; pc_src = v.pc_src;
        mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled 4 later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        #3;
        exp_cnt = 0;
        exp_q.push_back(O_IDLE);
        check_cycle("reset");
        check_val("reset_state", 32'(st), 32'(RUN));
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{0,0,0,0,0,0,0, 2'b00, 0,0,0, O_IDLE};
        vecs[1]  = '{5,0,0,0,5,0,0, 2'b01, 0,0,0, O_LW};
        vecs[2]  = '{0,0,5,0,0,5,0, 2'b00, 1,0,0, 12'b0000_000_10_00_0};
        vecs[3]  = '{0,0,0,7,0,7,7, 2'b00, 1,1,0, 12'b0000_000_00_10_0};
        vecs[4]  = '{0,0,0,0,0,0,0, 2'b00, 1,1,0, O_IDLE};
        vecs[5]  = '{0,0,9,3,0,3,9, 2'b00, 1,1,0, 12'b0000_000_01_10_0};
        vecs[6]  = '{0,0,0,7,0,7,7, 2'b00, 0,1,0, 12'b0000_000_00_01_0};
        vecs[7]  = '{0,0,0,0,0,0,0, 2'b00, 0,0,1, 12'b0000_110_00_00_0};
        vecs[8]  = '{0,0,0,0,0,0,0, 2'b01, 0,0,0, O_IDLE};
        vecs[9]  = '{0,6,0,0,6,0,0, 2'b01, 0,0,0, O_LW};
        vecs[10] = '{0,6,0,0,6,0,0, 2'b10, 0,0,0, O_IDLE};
        vecs[11] = '{0,0,4,4,0,4,0, 2'b00, 1,0,0, 12'b0000_000_10_10_0};
        vecs[12] = '{0,0,0,0,0,0,0, 2'b00, 1,1,0, O_IDLE};

        clear_inputs();
        do_reset();

        // Single-cycle vector table.
        for (int i = 0; i < 13; i++) begin
            apply_vec(vecs[i]);
            exp_q.push_back(vecs[i].exp);
            #4;
            check_cycle($sformatf("vec%0d", i));
            next_cycle();
        end

        // Memory hold: ready low 3 cycles, branch pending is suppressed.
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            clear_inputs();
            mem_req = 1'b1;
            pc_src  = 1'b1;
            exp_q.push_back(O_HOLD);
            #4;
            check_cycle($sformatf("hold%0d", k));
            next_cycle();
        end
        clear_inputs();
        mem_req = 1'b1; mem_ready = 1'b1;
        exp_q.push_back(O_IDLE);
        #4;
        check_cycle("hold_release");
        check_val("hold_state", 32'(st), 32'(MEM_WAIT));
        next_cycle();
        clear_inputs();
        exp_q.push_back(O_IDLE);
        #4;
        check_cycle("after_hold");
        check_val("after_hold_cnt3", 32'(cnt), 32'd3);
        next_cycle();

        // Timeout: ready never rises.
        do_reset();
        mem_req = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            exp_q.push_back((k == 16) ? O_ERR : O_HOLD);
            #4;
            check_cycle($sformatf("tmo%0d", k));
            next_cycle();
        end
        clear_inputs();
        exp_q.push_back(O_IDLE);
        #4;
        check_cycle("tmo_after");
        check_val("tmo_state", 32'(st), 32'(RUN));
        next_cycle();

        // Asynchronous reset in the middle of a memory wait.
        do_reset();
        mem_req = 1'b1;
        next_cycle();
        next_cycle();
        check_val("arst_pre_state", 32'(st), 32'(MEM_WAIT));
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        exp_q.push_back(O_IDLE);
        check_cycle("arst");
        check_val("arst_state", 32'(st), 32'(RUN));
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Saturation of a 2-bit counter under continuous load-use stalls.
        do_reset();
        apply_vec(vecs[1]);
        for (int k = 0; k < 6; k++) begin
            #4;
            check_val($sformatf("sat%0d", k), 32'(z_cnt), (k > 3) ? 32'd3 : 32'(k));
            next_cycle();
        end
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
